// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback mux, 32x32 register file with bypassed read ports
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [DATA_W-1:0] Memdata_i,
    input  logic [DATA_W-1:0] ALUresult_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic              WBvalid_o,
    output logic [ADDR_W-1:0] WBaddr_o,
    output logic [15:0]       WRcount_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;

    assign WBdata_o  = MemtoReg_i ? Memdata_i : ALUresult_i;
    assign WBvalid_o = RegWrite_i && (RDaddr_i != '0);
    assign WBaddr_o  = RDaddr_i;
    assign WRcount_o = wr_count_q;

    always_comb begin
        wr_count_d = wr_count_q + 16'd1;
    end

    // Entry 0 is reset but never written; reads of address 0 are forced to zero below.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (WBvalid_o) begin
            regs_q[RDaddr_i] <= WBdata_o;
            wr_count_q       <= wr_count_d;
        end
    end

    // Same-cycle bypass lets ID see the value being committed at this edge.
    always_comb begin
        RSdata_o = regs_q[RSaddr_i];
        if (RSaddr_i == '0) begin
            RSdata_o = '0;
        end else if (WBvalid_o && (RSaddr_i == RDaddr_i)) begin
            RSdata_o = WBdata_o;
        end
    end

    always_comb begin
        RTdata_o = regs_q[RTaddr_i];
        if (RTaddr_i == '0) begin
            RTdata_o = '0;
        end else if (WBvalid_o && (RTaddr_i == RDaddr_i)) begin
            RTdata_o = WBdata_o;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
`timescale 1ns/10ps
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemtoReg, RegWrite;
    logic [4:0]  RDaddr, RSaddr, RTaddr, WBaddr;
    logic [31:0] Memdata, ALUresult, RSdata, RTdata, WBdata;
    logic        WBvalid;
    logic [15:0] WRcount;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [32];
    logic [15:0] mcnt;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .MemtoReg_i(MemtoReg), .RegWrite_i(RegWrite), .RDaddr_i(RDaddr),
        .Memdata_i(Memdata), .ALUresult_i(ALUresult),
        .RSaddr_i(RSaddr), .RTaddr_i(RTaddr),
        .RSdata_o(RSdata), .RTdata_o(RTdata),
        .WBdata_o(WBdata), .WBvalid_o(WBvalid), .WBaddr_o(WBaddr),
        .WRcount_o(WRcount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_wbdata();
        return MemtoReg ? Memdata : ALUresult;
    endfunction

    function automatic logic m_wbvalid();
        return RegWrite && (RDaddr != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (m_wbvalid() && a == RDaddr) return m_wbdata();
        return mem[a];
    endfunction

    // Architectural model: register array plus commit counter.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            mcnt = 16'h0;
        end else if (m_wbvalid()) begin
            mem[RDaddr] = m_wbdata();
            mcnt = mcnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        chk("wbdata",  WBdata, m_wbdata());
        chk("wbvalid", {31'h0, WBvalid}, {31'h0, m_wbvalid()});
        chk("wbaddr",  {27'h0, WBaddr}, {27'h0, RDaddr});
        chk("rsdata",  RSdata, m_read(RSaddr));
        chk("rtdata",  RTdata, m_read(RTaddr));
        chk("wrcount", {16'h0, WRcount}, {16'h0, mcnt});
    end

    initial begin
        rst = 1'b1; RegWrite = 1'b0; MemtoReg = 1'b0; RDaddr = 5'd0;
        Memdata = 32'h0; ALUresult = 32'h0; RSaddr = 5'd0; RTaddr = 5'd0;
        #1;
        chk("reset_count", {16'h0, WRcount}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int a = 1; a < 32; a++) begin
            RegWrite = 1'b1; RDaddr = 5'(a); ALUresult = 32'h1000_0000 + 32'(a);
            step();
        end
        RegWrite = 1'b0; RSaddr = 5'd31;
        #1;
        chk("fill_r31", RSdata, 32'h1000_001F);
        chk("fill_count", {16'h0, WRcount}, 32'd31);

        rst = 1'b1;
        for (int a = 1; a < 32; a++) begin
            RSaddr = 5'(a); RTaddr = 5'(a);
            #0.1;
            chk("async_rst_rs", RSdata, 32'h0);
            chk("async_rst_rt", RTdata, 32'h0);
        end
        chk("async_rst_count", {16'h0, WRcount}, 32'h0);
        step();
        rst = 1'b0;

        RegWrite = 1'b1; MemtoReg = 1'b0; RDaddr = 5'd5; ALUresult = 32'h1234_5678;
        step();
        RegWrite = 1'b0; RSaddr = 5'd5;
        #1;
        chk("alu_wb_r5", RSdata, 32'h1234_5678);
        chk("alu_wb_count", {16'h0, WRcount}, 32'd1);

        step();
        MemtoReg = 1'b1; Memdata = 32'hDEAD_BEEF; RDaddr = 5'd9;
        RSaddr = 5'd9; RTaddr = 5'd9; RegWrite = 1'b1;
        #1;
        chk("bypass_rs", RSdata, 32'hDEAD_BEEF);
        chk("bypass_rt", RTdata, 32'hDEAD_BEEF);
        chk("bypass_count_pre", {16'h0, WRcount}, 32'd1);
        step();
        RegWrite = 1'b0;
        #1;
        chk("load_persist_rs", RSdata, 32'hDEAD_BEEF);
        chk("load_persist_rt", RTdata, 32'hDEAD_BEEF);
        chk("load_count", {16'h0, WRcount}, 32'd2);

        RegWrite = 1'b1; MemtoReg = 1'b0; RDaddr = 5'd0; ALUresult = 32'hFFFF_FFFF;
        RSaddr = 5'd0; RTaddr = 5'd0;
        #1;
        chk("r0_wbvalid", {31'h0, WBvalid}, 32'h0);
        chk("r0_read", RSdata, 32'h0);
        chk("r0_wbdata", WBdata, 32'hFFFF_FFFF);
        step();
        chk("r0_count", {16'h0, WRcount}, 32'd2);

        RDaddr = 5'd7; ALUresult = 32'h11; RegWrite = 1'b1;
        step();
        RegWrite = 1'b0; ALUresult = 32'hAAAA_AAAA; RSaddr = 5'd7;
        #1;
        chk("dis_no_bypass", RSdata, 32'h11);
        chk("dis_wbvalid", {31'h0, WBvalid}, 32'h0);
        chk("dis_wbdata", WBdata, 32'hAAAA_AAAA);
        step();
        chk("dis_r7_kept", RSdata, 32'h11);
        chk("dis_count", {16'h0, WRcount}, 32'd3);

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            RegWrite = 1'b1; RDaddr = 5'((i % 31) + 1);
            ALUresult = 32'(i); Memdata = ~32'(i); MemtoReg = i[0];
            step();
            if (i == 65534) chk("count_ffff", {16'h0, WRcount}, 32'h0000_FFFF);
        end
        RegWrite = 1'b0;
        #1;
        chk("count_wrap", {16'h0, WRcount}, 32'h0);

        RegWrite = 1'b1; MemtoReg = 1'b0; RDaddr = 5'd3; ALUresult = 32'h42;
        step();
        RegWrite = 1'b0; RSaddr = 5'd3;
        #1;
        chk("r3_written", RSdata, 32'h42);
        chk("r3_count", {16'h0, WRcount}, 32'd1);

        RDaddr = 5'd4; ALUresult = 32'h77; RegWrite = 1'b1;
        #5 rst = 1'b1;
        step();
        RegWrite = 1'b0; RSaddr = 5'd3; RTaddr = 5'd4;
        #1;
        chk("rst_r3_cleared", RSdata, 32'h0);
        chk("rst_r4_lost", RTdata, 32'h0);
        chk("rst_count", {16'h0, WRcount}, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_r3", RSdata, 32'h0);
        RegWrite = 1'b1; RDaddr = 5'd4; ALUresult = 32'h55;
        step();
        RegWrite = 1'b0;
        #1;
        chk("first_commit_r4", RTdata, 32'h55);
        chk("first_commit_count", {16'h0, WRcount}, 32'd1);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage consumer of the MEM/WB pipeline register outputs. It selects the writeback value (memory data or ALU result) and commits it to a 32x32 general-purpose register file. It also serves the two ID-stage read ports with same-cycle write-through bypass. It exports the current writeback tuple so the forwarding unit can compare against it.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register address width (file depth = 2**ADDR_W)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
MemtoReg_i  input  1  from MEM/WB: 1 selects Memdata_i, 0 selects ALUresult_i
RegWrite_i  input  1  from MEM/WB: write enable
RDaddr_i  input  ADDR_W  from MEM/WB: destination register
Memdata_i  input  DATA_W  from MEM/WB: load data
ALUresult_i  input  DATA_W  from MEM/WB: ALU result
RSaddr_i  input  ADDR_W  ID read port A address
RTaddr_i  input  ADDR_W  ID read port B address
RSdata_o  output  DATA_W  read port A data
RTdata_o  output  DATA_W  read port B data
WBdata_o  output  DATA_W  selected writeback value, combinational
WBvalid_o  output  1  RegWrite_i AND (RDaddr_i != 0), combinational
WBaddr_o  output  ADDR_W  equals RDaddr_i
WRcount_o  output  16  count of committed writes

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is asynchronous and active-high.
- Reset: all registers r[0..31] = 0 and WRcount_o = 0, immediately on assertion with no clock edge required. While rst_i is high, any write is blocked.
- Writeback mux: WBdata_o = MemtoReg_i ? Memdata_i : ALUresult_i. Pure combinational; valid during reset.
- Commit: on rising clk_i with rst_i low and WBvalid_o = 1, r[RDaddr_i] <= WBdata_o.
  - WRcount_o increments by 1 on each commit.
  - WRcount_o wraps 0xFFFF -> 0x0000.
- Register 0:
  - Hardwired zero. Writes to address 0 are discarded and not counted (WBvalid_o = 0).
  - Any read of address 0 returns 0, including during a bypass.
- Read ports: combinational, zero-cycle latency.
  - RSdata_o = (RSaddr_i == 0) ? 0 : (WBvalid_o and RSaddr_i == RDaddr_i) ? WBdata_o : r[RSaddr_i].
  - RTdata_o follows the same rule using RTaddr_i.
  - Bypass makes a same-cycle write visible to ID before the edge. No separate half-cycle write is needed.
- Both read ports may address the same register, or the write target, simultaneously. Both then return identical values.
- RegWrite_i = 0: no state change. Outputs still reflect the mux, and WBvalid_o = 0.
- Reset mid-operation: a write pending at the edge coincident with reset assertion is lost. After release, the file reads all zeros. The first edge after deassertion commits normally.
- No X propagation: all outputs are driven from defined state after reset.

Test Plan:
- Reset: assert rst_i asynchronously between edges -> all reads of r1..r31 return 0 and WRcount_o = 0 before the next edge.
- ALU writeback: RegWrite_i = 1, MemtoReg_i = 0, RDaddr_i = 5, ALUresult_i = 0x1234_5678, one edge; then RSaddr_i = 5 -> RSdata_o = 0x1234_5678 and WRcount_o = 1.
- Load writeback plus bypass: MemtoReg_i = 1, Memdata_i = 0xDEAD_BEEF, RDaddr_i = 9, RSaddr_i = RTaddr_i = 9 before the edge -> both read ports show 0xDEAD_BEEF in the same cycle; the value persists after the edge.
- r0 protection: RegWrite_i = 1, RDaddr_i = 0, ALUresult_i = 0xFFFF_FFFF -> WBvalid_o = 0, RSaddr_i = 0 reads 0, and WRcount_o unchanged.
- Disabled write: RegWrite_i = 0, RDaddr_i = 7, data 0xAAAA_AAAA with r7 previously 0x11 -> r7 stays 0x11 and there is no bypass.
- Counter wrap and reset mid-stream: perform 65536 commits -> WRcount_o returns to 0. Then write r3 = 0x42 and pulse rst_i -> r3 reads 0 afterward.
